// File: rtl/mvm_host_sequencer.sv
// Command front-end for one mvm core: buffers a LOAD burst, replays it gap-free into
// the core, and returns the K result words that follow core_done through an output FIFO.
module mvm_host_sequencer #(
  parameter int K       = 8,
  parameter int B       = 8,
  parameter int OUT_LAT = 1,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [B-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*B-1:0] out_data,
  output logic           core_loadMatrix,
  output logic           core_loadVector,
  output logic           core_start,
  output logic [B-1:0]   core_data_in,
  input  logic           core_done,
  input  logic [2*B-1:0] core_data_out,
  output logic           busy,
  output logic [1:0]     err
);
  localparam int NN  = K * K;
  localparam int PW  = $clog2(NN);
  localparam int CW  = (K > 1) ? $clog2(K) : 1;
  localparam int FCW = $clog2(K + 1);
  localparam int GW  = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW  = (OUT_LAT > 1) ? $clog2(OUT_LAT) : 1;

  localparam logic [PW-1:0] MAT_LAST = PW'(NN - 1);
  localparam logic [PW-1:0] VEC_LAST = PW'(K - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(K - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LD   = GW'(GAP);
  localparam logic [LW-1:0] LAT_LD   = LW'(OUT_LAT - 1);

  localparam logic [1:0] OP_LM  = 2'd0;
  localparam logic [1:0] OP_LV  = 2'd1;
  localparam logic [1:0] OP_RUN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_LAUNCH_LOAD, S_BURST, S_LAUNCH_RUN, S_WAIT_DONE, S_CAPTURE
  } state_t;

  state_t         r_state, w_nxt;
  logic [B-1:0]   r_buf [NN];
  logic [PW-1:0]  r_wp, r_rp, w_last;
  logic           r_is_mat, r_mat_ok, r_vec_ok;
  logic [GW-1:0]  r_gap;
  logic [TW-1:0]  r_tmo;
  logic [CW-1:0]  r_cap;
  logic [LW-1:0]  r_skip;
  logic [1:0]     r_err;
  logic [2*B-1:0] r_fifo [K];
  logic [CW-1:0]  r_fwp, r_frp;
  logic [FCW-1:0] r_fcnt;
  logic           w_cmd_fire, w_in_fire, w_push, w_pop;

  assign w_last = r_is_mat ? MAT_LAST : VEC_LAST;

  // A RUN is held off while results are still queued so the FIFO can never overflow.
  assign cmd_ready  = (r_state == S_IDLE) && (r_gap == '0) &&
                      !((cmd_op == OP_RUN) && (r_fcnt != '0));
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign in_ready   = (r_state == S_FILL);
  assign w_in_fire  = in_valid && in_ready;
  assign w_push     = (r_state == S_CAPTURE) && (r_skip == '0);
  assign w_pop      = out_valid && out_ready;

  // Core-facing strobes are masked by reset so nothing reaches the core in the reset cycle.
  assign core_loadMatrix = !reset && (r_state == S_LAUNCH_LOAD) && r_is_mat;
  assign core_loadVector = !reset && (r_state == S_LAUNCH_LOAD) && !r_is_mat;
  assign core_start      = !reset && (r_state == S_LAUNCH_RUN);
  assign core_data_in    = (!reset && (r_state == S_BURST)) ? r_buf[r_rp] : '0;

  assign out_valid = (r_fcnt != '0);
  assign out_data  = r_fifo[r_frp];
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          case (cmd_op)
            OP_LM, OP_LV: w_nxt = S_FILL;
            OP_RUN:       if (r_mat_ok && r_vec_ok) w_nxt = S_LAUNCH_RUN;
            default:      w_nxt = S_IDLE;
          endcase
        end
      end
      S_FILL:        if (w_in_fire && (r_wp == w_last)) w_nxt = S_LAUNCH_LOAD;
      S_LAUNCH_LOAD: w_nxt = S_BURST;
      S_BURST:       if (r_rp == w_last) w_nxt = S_IDLE;
      S_LAUNCH_RUN:  w_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (core_done)              w_nxt = S_CAPTURE;
        else if (r_tmo == TMO_LAST) w_nxt = S_IDLE;
      end
      S_CAPTURE:     if (w_push && (r_cap == CAP_LAST)) w_nxt = S_IDLE;
      default:       w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_mat <= 1'b0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_gap    <= '0;
      r_tmo    <= '0;
      r_cap    <= '0;
      r_skip   <= '0;
      r_mat_ok <= 1'b0;
      r_vec_ok <= 1'b0;
      r_err    <= '0;
      for (int i = 0; i < NN; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_gap != '0) r_gap <= r_gap - 1'b1;
          if (w_cmd_fire) begin
            case (cmd_op)
              OP_LM:   begin r_is_mat <= 1'b1; r_mat_ok <= 1'b0; r_wp <= '0; end
              OP_LV:   begin r_is_mat <= 1'b0; r_vec_ok <= 1'b0; r_wp <= '0; end
              OP_RUN:  if (!(r_mat_ok && r_vec_ok)) r_err[0] <= 1'b1;
              default: r_err[0] <= 1'b1;
            endcase
          end
        end
        S_FILL: begin
          if (w_in_fire) begin
            r_buf[r_wp] <= in_data;
            r_wp        <= r_wp + 1'b1;
          end
        end
        S_LAUNCH_LOAD: r_rp <= '0;
        S_BURST: begin
          r_rp <= r_rp + 1'b1;
          if (r_rp == w_last) begin
            if (r_is_mat) r_mat_ok <= 1'b1;
            else          r_vec_ok <= 1'b1;
            r_gap <= GAP_LD;
          end
        end
        S_LAUNCH_RUN: r_tmo <= '0;
        S_WAIT_DONE: begin
          if (core_done) begin
            r_cap  <= '0;
            r_skip <= LAT_LD;
          end else if (r_tmo == TMO_LAST) begin
            // Core state is unknown after an abort, so both operands must be reloaded.
            r_err[1] <= 1'b1;
            r_mat_ok <= 1'b0;
            r_vec_ok <= 1'b0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (r_skip != '0) begin
            r_skip <= r_skip - 1'b1;
          end else begin
            r_cap <= r_cap + 1'b1;
            if (r_cap == CAP_LAST) r_gap <= GAP_LD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwp  <= '0;
      r_frp  <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < K; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_fwp] <= core_data_out;
        r_fwp         <= (r_fwp == CAP_LAST) ? '0 : r_fwp + 1'b1;
      end
      if (w_pop) r_frp <= (r_frp == CAP_LAST) ? '0 : r_frp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_host_sequencer.sv
// Directed bench for mvm_host_sequencer with a behavioural mvm core attached.
module tb_mvm_host_sequencer;
  localparam logic [1:0] OP_LM = 2'd0, OP_LV = 2'd1, OP_RUN = 2'd2, OP_BAD = 2'd3;

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'd0;
  logic out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic core_loadMatrix, core_loadVector, core_start;
  logic [7:0] core_data_in;
  logic core_done = 1'b0;
  logic [15:0] core_data_out = 16'd0;
  logic busy;
  logic [1:0] err;

  always #5 clk = ~clk;

  mvm_host_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_loadMatrix(core_loadMatrix), .core_loadVector(core_loadVector), .core_start(core_start),
    .core_data_in(core_data_in), .core_done(core_done), .core_data_out(core_data_out),
    .busy(busy), .err(err)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: captures bursts after each load pulse, answers start with done + K words.
  logic signed [7:0]  mm [64];
  logic signed [7:0]  xv [8];
  logic signed [15:0] yv [8];
  int ld_cnt = 0, ld_idx = 0, ph = 0;
  bit ld_mat = 1'b0, suppress = 1'b0;
  int cnt_lm = 0, cnt_lv = 0, cnt_st = 0, viol = 0, pulse_cyc = 0;
  logic p_lm = 1'b0, p_lv = 1'b0, p_st = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      if (core_loadMatrix || core_loadVector || core_start) viol++;
      ld_cnt = 0; ld_idx = 0; ph = 0;
      p_lm = 1'b0; p_lv = 1'b0; p_st = 1'b0;
      core_done <= 1'b0;
      core_data_out <= 16'd0;
    end else begin
      if (int'(core_loadMatrix) + int'(core_loadVector) + int'(core_start) > 1) viol++;
      if ((core_loadMatrix && p_lm) || (core_loadVector && p_lv) || (core_start && p_st)) viol++;
      p_lm = core_loadMatrix; p_lv = core_loadVector; p_st = core_start;
      if (ld_cnt != 0) begin
        if (ld_mat) mm[ld_idx] = core_data_in;
        else        xv[ld_idx] = core_data_in;
        ld_idx++; ld_cnt--;
      end
      if (core_loadMatrix) begin ld_mat = 1'b1; ld_idx = 0; ld_cnt = 64; cnt_lm++; pulse_cyc = cyc; end
      if (core_loadVector) begin ld_mat = 1'b0; ld_idx = 0; ld_cnt = 8; cnt_lv++; pulse_cyc = cyc; end
      if (ph != 0) begin ph++; if (ph > 12) ph = 0; end
      if (core_start) begin
        cnt_st++; pulse_cyc = cyc;
        if (!suppress) begin
          for (int i = 0; i < 8; i++) begin
            int s;
            s = 0;
            for (int j = 0; j < 8; j++) s += int'(mm[i*8+j]) * int'(xv[j]);
            yv[i] = 16'(s);
          end
          ph = 1;
        end
      end
      core_done <= (ph == 4);
      if (ph >= 5) core_data_out <= yv[ph-5];
      else         core_data_out <= 16'h0bad;
    end
  end

  typedef struct packed {
    logic [1:0]       mmode;
    logic [1:0]       vmode;
    logic             tog;
    logic             gap3;
    logic [7:0][15:0] y;
  } vec_t;
  vec_t tv [3];

  logic [7:0] wbuf [64];
  logic signed [15:0] res [16];
  int nres, acc_cyc, last_acc;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mat_elem(input int mode, input int idx);
    int i, j, v;
    i = idx / 8; j = idx % 8;
    case (mode)
      0:       v = idx + 1;
      1:       v = (i == j) ? 1 : 0;
      default: v = i - 4;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [7:0] vec_elem(input int mode, input int j);
    int v;
    case (mode)
      0:       v = 1;
      1:       v = -128 + j;
      default: v = j + 1;
    endcase
    return 8'(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int n;
    n = 0;
    cmd_op = op; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready low for %0d cycles, expected 1", n);
    end
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    int i, t;
    bit hs;
    i = 0; t = 0;
    while (i < n && t < 1000) begin
      in_valid = !(gaps && (t % 3 == 2));
      in_data = wbuf[i];
      #1;
      hs = in_valid && in_ready;
      if (hs) last_acc = cyc;
      @(negedge clk);
      if (hs) i++;
      t++;
    end
    in_valid = 1'b0;
    if (i < n) begin
      n_chk++; n_fail++;
      $display("FAIL feed: accepted %0d words, expected %0d", i, n);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while (busy && n < 300) begin @(negedge clk); #1; n++; end
    if (busy) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, expected 0", n);
    end
    @(negedge clk);
  endtask

  task automatic load(input bit mat, input int mode, input bit gaps);
    int n, mism;
    n = mat ? 64 : 8;
    for (int i = 0; i < n; i++) wbuf[i] = mat ? mat_elem(mode, i) : vec_elem(mode, i);
    send_cmd(mat ? OP_LM : OP_LV);
    feed(n, gaps);
    wait_idle();
    mism = 0;
    for (int i = 0; i < n; i++)
      if ((mat ? mm[i] : xv[i]) !== wbuf[i]) mism++;
    check(mat ? "burst_words_mat" : "burst_words_vec", mism, 0);
  endtask

  task automatic collect(input int n, input bit tog);
    int t, extra;
    t = 0; nres = 0;
    while (nres < n && t < 200) begin
      out_ready = tog ? (t % 2 == 1) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (nres < 16) res[nres] = out_data;
        nres++;
      end
      @(negedge clk);
      t++;
    end
    extra = 0;
    out_ready = 1'b1;
    repeat (6) begin
      #1;
      if (out_valid) extra++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("result_count", nres, n);
    check("result_extra", extra, 0);
  endtask

  task automatic check_y(input int r);
    for (int k = 0; k < 8; k++)
      check($sformatf("rec%0d_y%0d", r, k), int'(res[k]), int'($signed(tv[r].y[k])));
  endtask

  initial begin
    int lm0, lv0, st0, n, e_cyc;
    tv[0] = {2'd0, 2'd0, 1'b0, 1'b0, {16'sd484, 16'sd420, 16'sd356, 16'sd292,
                                      16'sd228, 16'sd164, 16'sd100, 16'sd36}};
    tv[1] = {2'd1, 2'd1, 1'b1, 1'b1, {-16'sd121, -16'sd122, -16'sd123, -16'sd124,
                                      -16'sd125, -16'sd126, -16'sd127, -16'sd128}};
    tv[2] = {2'd2, 2'd2, 1'b0, 1'b0, {16'sd108, 16'sd72, 16'sd36, 16'sd0,
                                      -16'sd36, -16'sd72, -16'sd108, -16'sd144}};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_pulses", int'({core_loadMatrix, core_loadVector, core_start}), 0);
    check("rst_core_data_in", int'(core_data_in), 0);
    @(negedge clk);

    send_cmd(OP_RUN);
    repeat (3) @(negedge clk);
    #1;
    check("early_run_err", int'(err), 1);
    check("early_run_no_start", cnt_st, 0);
    check("early_run_cmd_ready", int'(cmd_ready), 1);
    check("early_run_busy", int'(busy), 0);
    do_reset();
    @(negedge clk);
    send_cmd(OP_BAD);
    #1;
    check("illegal_op_err", int'(err), 1);
    do_reset();
    @(negedge clk);

    for (int r = 0; r < 3; r++) begin
      lm0 = cnt_lm; lv0 = cnt_lv; st0 = cnt_st;
      load(1'b1, int'(tv[r].mmode), tv[r].gap3);
      if (tv[r].gap3) check("pulse_after_last_word", pulse_cyc - last_acc, 1);
      load(1'b0, int'(tv[r].vmode), 1'b0);
      check("vec_cmd_to_pulse", pulse_cyc - acc_cyc, 9);
      send_cmd(OP_RUN);
      collect(8, tv[r].tog);
      check_y(r);
      check("lm_pulses", cnt_lm - lm0, 1);
      check("lv_pulses", cnt_lv - lv0, 1);
      check("st_pulses", cnt_st - st0, 1);
      check("run_err", int'(err), 0);
    end

    // Repeat RUN on stored operands, leaving results queued to exercise the RUN hold-off.
    st0 = cnt_st;
    send_cmd(OP_RUN);
    repeat (20) @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_RUN;
    #1;
    check("fifo_full_valid", int'(out_valid), 1);
    check("run_held_cmd_ready", int'(cmd_ready), 0);
    cmd_op = OP_LM;
    #1;
    check("load_ok_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    collect(8, 1'b1);
    check_y(2);
    cmd_op = OP_RUN;
    #1;
    check("run_after_drain_ready", int'(cmd_ready), 1);
    check("rerun_st_pulses", cnt_st - st0, 1);
    @(negedge clk);

    suppress = 1'b1;
    st0 = cnt_st;
    send_cmd(OP_RUN);
    n = 0; e_cyc = 0;
    #1;
    while (!err[1] && n < 1200) begin
      if (n == 900) check("timeout_busy_mid", int'(busy), 1);
      @(negedge clk); #1; n++;
    end
    e_cyc = cyc;
    check("timeout_seen", int'(err[1]), 1);
    check("timeout_wait_cycles", e_cyc - pulse_cyc - 1, 1023);
    check("timeout_busy", int'(busy), 0);
    @(negedge clk);
    send_cmd(OP_RUN);
    repeat (3) @(negedge clk);
    #1;
    check("post_timeout_err", int'(err), 3);
    check("post_timeout_starts", cnt_st - st0, 1);
    check("post_timeout_out_valid", int'(out_valid), 0);
    suppress = 1'b0;

    do_reset();
    @(negedge clk);
    load(1'b1, 0, 1'b0);
    load(1'b0, 0, 1'b0);
    for (int i = 0; i < 64; i++) wbuf[i] = mat_elem(2, i);
    send_cmd(OP_LM);
    feed(64, 1'b0);
    n = 0;
    while (!(ld_cnt != 0 && ld_idx == 20) && n < 100) begin @(negedge clk); n++; end
    check("reached_word20", ld_idx, 20);
    reset = 1'b1;
    #1;
    check("rst_cycle_pulses", int'({core_loadMatrix, core_loadVector, core_start}), 0);
    check("rst_cycle_data_in", int'(core_data_in), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_data_in", int'(core_data_in), 0);
    @(negedge clk);
    st0 = cnt_st;
    send_cmd(OP_RUN);
    #1;
    check("mid_rst_flags_cleared", int'(err), 1);
    check("mid_rst_no_start", cnt_st - st0, 0);
    load(1'b1, 0, 1'b0);
    load(1'b0, 0, 1'b0);
    send_cmd(OP_RUN);
    collect(8, 1'b0);
    check_y(0);

    check("pulse_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mvm_host_sequencer.md
Name: mvm_host_sequencer

Overview:
- Command-driven front-end that sequences one mvm_K_P_B_G core (K=P=8, B=8, G=1) on behalf of a host-side streaming interface.
- Accepts LOAD_MATRIX, LOAD_VECTOR and RUN commands over a valid/ready handshake.
- Buffers each input burst completely before replaying it gap-free into the core, which cannot stall.
- Captures the K result words that follow done and returns them through an output valid/ready FIFO.

Parameters:
- K, 8, matrix dimension; matrix burst = K*K words, vector burst = K words
- B, 8, input word width; result width is 2*B
- OUT_LAT, 1, cycles from core_done high to the first valid core_data_out word
- GAP, 2, idle cycles enforced after any core burst before the next core pulse
- TIMEOUT, 1023, maximum cycles in WAIT_DONE before aborting

Ports:
- clk, in, 1, rising-edge clock
- reset, in, 1, synchronous active-high reset
- cmd_valid, in, 1, command present
- cmd_ready, out, 1, sequencer accepts command
- cmd_op, in, 2, 0=LOAD_MATRIX, 1=LOAD_VECTOR, 2=RUN, 3=illegal
- in_valid, in, 1, input word present
- in_ready, out, 1, input word accepted
- in_data, in, B, signed matrix/vector element, row-major for the matrix
- out_valid, out, 1, result word present
- out_ready, in, 1, host accepts result
- out_data, out, 2B, signed y element, y[0] first
- core_loadMatrix, out, 1, one-cycle pulse to core
- core_loadVector, out, 1, one-cycle pulse to core
- core_start, out, 1, one-cycle pulse to core
- core_data_in, out, B, word driven to core
- core_done, in, 1, core completion flag
- core_data_out, in, 2B, core result stream
- busy, out, 1, high whenever state != IDLE
- err, out, 2, sticky: bit0 = illegal/unready command, bit1 = timeout; cleared only by reset

Behaviour:
- Reset, synchronous: state=IDLE; all outputs 0 except cmd_ready=1; buffers empty; mat_ok=vec_ok=0; err=0.
- cmd handshake: a command transfers when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE, once the GAP counter has expired.
- Input buffer: K*K x B entries. The write pointer is reset on each load command.
- States:
  - IDLE:
    - LOAD_* -> FILL, target N = K*K (matrix) or K (vector).
    - RUN with mat_ok && vec_ok && output FIFO empty -> LAUNCH_RUN.
    - RUN missing either flag -> set err[0], stay IDLE (command consumed).
    - RUN with output FIFO non-empty -> cmd_ready held 0 until the FIFO drains.
    - op 3 -> set err[0], consumed.
  - FILL:
    - in_ready=1. Each in handshake writes buf[wp++].
    - When wp reaches N-1 and that word is accepted -> LAUNCH_LOAD. in_ready drops the next cycle.
    - No timeout while filling.
  - LAUNCH_LOAD: assert core_loadMatrix or core_loadVector for exactly 1 cycle, rp=0 -> BURST.
  - BURST:
    - core_data_in = buf[rp] on N consecutive cycles; first word in the cycle after the pulse.
    - After the last word: set mat_ok or vec_ok, load the GAP counter -> IDLE.
    - Outside BURST, core_data_in = 0.
  - LAUNCH_RUN: core_start for 1 cycle, clear the timeout counter -> WAIT_DONE.
  - WAIT_DONE:
    - On the first cycle core_done=1 -> CAPTURE, skipping OUT_LAT-1 further cycles.
    - If the counter reaches TIMEOUT first -> set err[1], clear mat_ok and vec_ok -> IDLE.
  - CAPTURE: push core_data_out into the output FIFO on K consecutive cycles, starting OUT_LAT cycles after done rose. Then load GAP -> IDLE.
- Output FIFO:
  - Depth K, 2B wide.
  - out_valid = !empty; out_data = head.
  - Pop on out_valid && out_ready.
  - It never overflows because RUN is gated on empty.
  - A push and a pop in the same cycle are both honoured.
- mat_ok and vec_ok persist across RUNs: repeated RUN reuses the core's stored operands. A new LOAD of the same kind clears that flag at FILL entry.
- core_* pulses are never asserted concurrently, and never during reset.
- Reset mid-operation:
  - The sequencer returns to IDLE immediately.
  - Pulses are deasserted in the reset cycle.
  - Buffers and FIFO are emptied.
  - The flags clear, so the host must reload both operands.
- Latency:
  - Command accept to core pulse: FILL length + 1 cycle.
  - Last result captured to out_valid: 1 cycle.

Test Plan:
- Reset, then LOAD_MATRIX with elements 1..64, LOAD_VECTOR with all 1s, RUN -> core sees each pulse once, 64 then 8 gap-free words; out_data = row sums 36,100,164,...,484.
- Identity matrix, x = -128..-121, out_ready toggled 50% -> y = -128..-121 in order; the FIFO never drops or duplicates a word.
- RUN immediately after reset -> err=01, no core_start, cmd_ready stays 1.
- core_done held low after start -> after 1023 cycles err[1]=1, state IDLE, next RUN flagged err[0].
- in_valid gaps during FILL (every 3rd cycle) -> BURST still 64 contiguous cycles, pulse only after the last word arrives.
- Reset asserted mid-BURST (word 20) -> next cycle all outputs at reset values; a fresh load/run sequence produces correct results.
